// File: rtl/avalon_slave_regfile.sv
// Avalon-MM slave register file with byte-enable writes and a programmable
// wait-state handshake. Registers flagged in RO_MASK return the matching
// iStatus slice on read and ignore writes. Out-of-range reads return DEFAULT_RDATA.
// Optional feature macro: AVS_REGFILE_IRQ_EN adds an IRQ_PENDING word at index
// NUM_REGS (rising-edge set, write-1-to-clear), an IRQ_ENABLE word at index
// NUM_REGS+1, the iIrqSrc input and the ins_irq output.
module avalon_slave_regfile #(
   parameter int unsigned         DATA_WIDTH    = 32,
   parameter int unsigned         NUM_REGS      = 8,
   parameter int unsigned         ADDR_WIDTH    = 11,
   parameter int unsigned         WAIT_STATES   = 1,
   parameter logic [NUM_REGS-1:0] RO_MASK       = {NUM_REGS{1'b0}},
   parameter logic [63:0]         DEFAULT_RDATA = 64'h0000_0000_DEAD_BEEF
) (
   input  logic                           iClk,
   input  logic                           nReset,
   input  logic [ADDR_WIDTH-1:0]          avs_address,
   input  logic [DATA_WIDTH/8-1:0]        avs_byteenable,
   input  logic                           avs_read,
   input  logic                           avs_write,
   input  logic [DATA_WIDTH-1:0]          avs_writedata,
   output logic [DATA_WIDTH-1:0]          avs_readdata,
   output logic                           avs_waitrequest,
   output logic [NUM_REGS*DATA_WIDTH-1:0] oRegs,
   output logic [NUM_REGS-1:0]            oWrStrobe,
`ifdef AVS_REGFILE_IRQ_EN
   input  logic [DATA_WIDTH-1:0]          iIrqSrc,
   output logic                           ins_irq,
`endif
   input  logic [NUM_REGS*DATA_WIDTH-1:0] iStatus
);

   localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
   localparam int unsigned WORD_LSB  = $clog2(NUM_LANES);
   localparam logic [3:0]  WS_LAST   = (WAIT_STATES > 32'd0) ? 4'(WAIT_STATES - 32'd1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [3:0]              cnt_r;
   logic [3:0]              cnt_s;
   logic                    req_s;
   logic [31:0]             idx_s;
   logic                    commit_wr_s;
   logic                    load_rd_s;
   logic                    be_any_s;
   logic [NUM_REGS-1:0]     reg_hit_s;
   logic [NUM_REGS-1:0]     wr_en_s;
   logic [DATA_WIDTH-1:0]   rd_val_s;
   logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];
   logic [NUM_REGS-1:0]     wr_strobe_r;
   logic [DATA_WIDTH-1:0]   readdata_r;

   // Expands byte enables into a per-bit mask.
   function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [NUM_LANES-1:0] be);
      logic [DATA_WIDTH-1:0] m;
      m = {DATA_WIDTH{1'b0}};
      for (int b = 0; b < NUM_LANES; b++) begin
         m[8*b +: 8] = {8{be[b]}};
      end
      return m;
   endfunction

   // Byte-lane merge: enabled lanes take new data, others keep the old value.
   function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_v,
                                                         input logic [DATA_WIDTH-1:0] new_v,
                                                         input logic [NUM_LANES-1:0] be);
      logic [DATA_WIDTH-1:0] m;
      m = lane_mask(be);
      return (old_v & ~m) | (new_v & m);
   endfunction

   assign req_s           = avs_read | avs_write;
   assign idx_s           = 32'(avs_address[ADDR_WIDTH-1:WORD_LSB]);
   assign avs_waitrequest = req_s & (state_r != ST_ACK);
   assign commit_wr_s     = (state_r == ST_ACK) & avs_write;
   assign load_rd_s       = (state_s == ST_ACK) & (state_r != ST_ACK) & avs_read & ~avs_write;
   assign be_any_s        = |avs_byteenable;
   assign avs_readdata    = readdata_r;
   assign oWrStrobe       = wr_strobe_r;

   genvar g;
   generate
      for (g = 0; g < NUM_REGS; g++) begin : g_oregs
         assign oRegs[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
      end
   endgenerate

   // FSM state and wait counter registers.
   always_ff @(posedge iClk or negedge nReset) begin
      if (!nReset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state logic: IDLE -> WAIT/ACK on request, WAIT counts, ACK always returns to IDLE.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            cnt_s = 4'd0;
            if (!req_s) begin
               state_s = ST_IDLE;
            end else if (WAIT_STATES == 32'd0) begin
               state_s = ST_ACK;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!req_s) begin
               state_s = ST_IDLE;
               cnt_s   = 4'd0;
            end else if (cnt_r == WS_LAST) begin
               state_s = ST_ACK;
               cnt_s   = 4'd0;
            end else begin
               state_s = ST_WAIT;
               cnt_s   = cnt_r + 4'd1;
            end
         end
         ST_ACK: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // Decode word index into register hits and qualified write enables.
   always_comb begin
      reg_hit_s = {NUM_REGS{1'b0}};
      wr_en_s   = {NUM_REGS{1'b0}};
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_hit_s[i] = (idx_s == 32'(i));
         wr_en_s[i]   = commit_wr_s & reg_hit_s[i] & ~RO_MASK[i] & be_any_s;
      end
   end

`ifdef AVS_REGFILE_IRQ_EN
   logic [DATA_WIDTH-1:0] irq_src_d_r;
   logic [DATA_WIDTH-1:0] irq_pend_r;
   logic [DATA_WIDTH-1:0] irq_en_r;
   logic [DATA_WIDTH-1:0] irq_pend_s;
   logic [DATA_WIDTH-1:0] irq_en_s;
   logic                  irq_r;

   // IRQ next values: clear by write-1 on enabled lanes, then rising-edge set wins.
   always_comb begin
      irq_pend_s = irq_pend_r;
      irq_en_s   = irq_en_r;
      if (commit_wr_s && (idx_s == NUM_REGS)) begin
         irq_pend_s = irq_pend_r & ~(avs_writedata & lane_mask(avs_byteenable));
      end else begin
         irq_pend_s = irq_pend_r;
      end
      irq_pend_s = irq_pend_s | (iIrqSrc & ~irq_src_d_r);
      if (commit_wr_s && (idx_s == NUM_REGS + 32'd1)) begin
         irq_en_s = merge_lanes(irq_en_r, avs_writedata, avs_byteenable);
      end else begin
         irq_en_s = irq_en_r;
      end
   end

   // IRQ state registers and registered interrupt output.
   always_ff @(posedge iClk or negedge nReset) begin
      if (!nReset) begin
         irq_src_d_r <= {DATA_WIDTH{1'b0}};
         irq_pend_r  <= {DATA_WIDTH{1'b0}};
         irq_en_r    <= {DATA_WIDTH{1'b0}};
         irq_r       <= 1'b0;
      end else begin
         irq_src_d_r <= iIrqSrc;
         irq_pend_r  <= irq_pend_s;
         irq_en_r    <= irq_en_s;
         irq_r       <= |(irq_pend_s & irq_en_s);
      end
   end

   assign ins_irq = irq_r;
`endif

   // Read mux: register, status slice for read-only words, IRQ words, else default.
   always_comb begin
      rd_val_s = DEFAULT_RDATA[DATA_WIDTH-1:0];
      for (int i = 0; i < NUM_REGS; i++) begin
         rd_val_s = reg_hit_s[i] ? (RO_MASK[i] ? iStatus[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i])
                                 : rd_val_s;
      end
`ifdef AVS_REGFILE_IRQ_EN
      rd_val_s = (idx_s == NUM_REGS)          ? irq_pend_r : rd_val_s;
      rd_val_s = (idx_s == NUM_REGS + 32'd1)  ? irq_en_r   : rd_val_s;
`endif
   end

   // Register storage: byte-lane merge on committed writes to writable words.
   always_ff @(posedge iClk or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en_s[i]) begin
               regs_r[i] <= merge_lanes(regs_r[i], avs_writedata, avs_byteenable);
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
      end
   end

   // Write strobes pulse for the cycle after commit; read data is valid only during ACK.
   always_ff @(posedge iClk or negedge nReset) begin
      if (!nReset) begin
         wr_strobe_r <= {NUM_REGS{1'b0}};
         readdata_r  <= {DATA_WIDTH{1'b0}};
      end else begin
         wr_strobe_r <= wr_en_s;
         readdata_r  <= load_rd_s ? rd_val_s : {DATA_WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_avalon_slave_regfile.sv
// Scoreboard bench for avalon_slave_regfile: read expectations are queued by the
// stimulus and consumed by a monitor when a read completes on the bus.
module tb_avalon_slave_regfile;

   localparam int DW = 32;
   localparam int NR = 8;
   localparam int AW = 11;

   logic              clk = 1'b0;
   logic              nreset = 1'b0;
   logic [AW-1:0]     address;
   logic [3:0]        be;
   logic              rd;
   logic              wr;
   logic [DW-1:0]     wdata;
   logic [DW-1:0]     rdata;
   logic              waitreq;
   logic [NR*DW-1:0]  oregs;
   logic [NR-1:0]     strobe;
   logic [NR*DW-1:0]  status;

   logic              rd0;
   logic [AW-1:0]     addr0;
   logic [DW-1:0]     rdata0;
   logic              waitreq0;
   logic [NR*DW-1:0]  oregs0;
   logic [NR-1:0]     strobe0;

`ifdef AVS_REGFILE_IRQ_EN
   logic [DW-1:0]     irq_src;
   logic              irq;
   logic              irq0;
`endif

   int                n_tests = 0;
   int                n_fail  = 0;
   logic [DW-1:0]     exp_q [$];
   int                strobe_cnt [NR];

   avalon_slave_regfile #(
      .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .WAIT_STATES(1),
      .RO_MASK(8'b0000_1000), .DEFAULT_RDATA(64'h0000_0000_DEAD_BEEF)
   ) dut (
      .iClk(clk), .nReset(nreset), .avs_address(address), .avs_byteenable(be),
      .avs_read(rd), .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdata),
      .avs_waitrequest(waitreq), .oRegs(oregs), .oWrStrobe(strobe),
`ifdef AVS_REGFILE_IRQ_EN
      .iIrqSrc(irq_src), .ins_irq(irq),
`endif
      .iStatus(status)
   );

   avalon_slave_regfile #(
      .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .WAIT_STATES(0),
      .RO_MASK(8'b0000_1000), .DEFAULT_RDATA(64'h0000_0000_DEAD_BEEF)
   ) dut0 (
      .iClk(clk), .nReset(nreset), .avs_address(addr0), .avs_byteenable(4'h0),
      .avs_read(rd0), .avs_write(1'b0), .avs_writedata(32'h0000_0000), .avs_readdata(rdata0),
      .avs_waitrequest(waitreq0), .oRegs(oregs0), .oWrStrobe(strobe0),
`ifdef AVS_REGFILE_IRQ_EN
      .iIrqSrc(irq_src), .ins_irq(irq0),
`endif
      .iStatus(status)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Monitor: a read completes when waitrequest is low with read (and not write) asserted.
   always @(negedge clk) begin
      if (nreset && rd && !wr && !waitreq) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_unexpected: got %h, required no read completion", rdata);
         end else begin
            check("rd_data", {32'd0, rdata}, {32'd0, exp_q.pop_front()});
         end
      end
   end

   // Count strobe pulses per register.
   always @(negedge clk) begin
      for (int i = 0; i < NR; i++) begin
         if (strobe[i]) strobe_cnt[i]++;
      end
   end

   task automatic xfer(input logic r, input logic w, input logic [AW-1:0] a, input logic [3:0] b,
                       input logic [DW-1:0] d, output int stalls, output logic [DW-1:0] rd_ack);
      @(posedge clk); #1;
      rd = r; wr = w; address = a; be = b; wdata = d;
      stalls = 0;
      @(negedge clk);
      while (waitreq && stalls < 40) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 40) begin
         n_tests++;
         n_fail++;
         $display("FAIL xfer_timeout: got %0d stall cycles, required completion", stalls);
      end
      rd_ack = rdata;
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
   endtask

   int            st;
   int            st0;
   logic [DW-1:0] ra;
   int            exp_strobe [NR];

   initial begin
      rd = 1'b0; wr = 1'b0; address = '0; be = 4'h0; wdata = 32'h0; rd0 = 1'b0; addr0 = 11'h3FC;
      status = '0;
      status[3*DW +: DW] = 32'h0000_CAFE;
`ifdef AVS_REGFILE_IRQ_EN
      irq_src = 32'h0;
`endif
      for (int i = 0; i < NR; i++) begin
         strobe_cnt[i] = 0;
         exp_strobe[i] = 0;
      end
      exp_strobe[1] = 1;
      exp_strobe[2] = 1;
      exp_strobe[4] = 1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      check("rst_oregs_any", {63'd0, |oregs}, 64'd0);
      check("rst_rdata", {32'd0, rdata}, 64'd0);
      check("rst_strobe", {56'd0, strobe}, 64'd0);
      check("rst_waitreq", {63'd0, waitreq}, 64'd0);

      // Reset while a write to reg 2 sits in WAIT.
      @(posedge clk); #1;
      wr = 1'b1; address = 11'h008; be = 4'hF; wdata = 32'h1111_2222;
      @(posedge clk); #1;
      check("midwait_waitreq", {63'd0, waitreq}, 64'd1);
      nreset = 1'b0; #1;
      check("rst_waitreq_follows_req", {63'd0, waitreq}, 64'd1);
      wr = 1'b0; #1;
      check("rst_waitreq_no_req", {63'd0, waitreq}, 64'd0);
      @(negedge clk);
      nreset = 1'b1;
      check("rst_reg2_clear", {32'd0, oregs[2*DW +: DW]}, 64'd0);

      // Full write to reg 2: two stall cycles, one strobe.
      xfer(1'b0, 1'b1, 11'h008, 4'hF, 32'hA5A5_1234, st, ra);
      check("wr_reg2_stalls", 64'(st), 64'd2);
      check("wr_reg2_value", {32'd0, oregs[2*DW +: DW]}, 64'h0000_0000_A5A5_1234);
      check("wr_reg2_strobe", {56'd0, strobe}, 64'h04);
      @(posedge clk); #1;
      check("wr_reg2_strobe_end", {56'd0, strobe}, 64'h00);

      // Read reg 2 back; readdata drops after ACK.
      exp_q.push_back(32'hA5A5_1234);
      xfer(1'b1, 1'b0, 11'h008, 4'h0, 32'h0, st, ra);
      check("rd_reg2_stalls", 64'(st), 64'd2);
      check("rd_zero_after_ack", {32'd0, rdata}, 64'd0);

      // Partial byte-enable write, then an all-zero byte-enable write.
      xfer(1'b0, 1'b1, 11'h004, 4'b0101, 32'hFFFF_FFFF, st, ra);
      check("wr_reg1_be0101", {32'd0, oregs[1*DW +: DW]}, 64'h0000_0000_00FF_00FF);
      xfer(1'b0, 1'b1, 11'h004, 4'b0000, 32'h1234_5678, st, ra);
      check("wr_reg1_be0_hold", {32'd0, oregs[1*DW +: DW]}, 64'h0000_0000_00FF_00FF);

      // Read-only reg 3 ignores writes and reads iStatus.
      xfer(1'b0, 1'b1, 11'h00C, 4'hF, 32'h0000_0001, st, ra);
      check("wr_ro_reg3_ignored", {32'd0, oregs[3*DW +: DW]}, 64'd0);
      exp_q.push_back(32'h0000_CAFE);
      xfer(1'b1, 1'b0, 11'h00C, 4'hF, 32'h0, st, ra);

      // Out-of-range reads return the default word.
      exp_q.push_back(32'hDEAD_BEEF);
      xfer(1'b1, 1'b0, 11'h3FC, 4'h0, 32'h0, st, ra);
      exp_q.push_back(32'hDEAD_BEEF);
      xfer(1'b1, 1'b0, 11'h040, 4'h0, 32'h0, st, ra);
      exp_q.push_back(32'h00FF_00FF);
      xfer(1'b1, 1'b0, 11'h004, 4'hF, 32'h0, st, ra);

      // Simultaneous read and write: write wins, readdata stays 0.
      xfer(1'b1, 1'b1, 11'h010, 4'hF, 32'h1122_3344, st, ra);
      check("rdwr_rdata_zero", {32'd0, ra}, 64'd0);
      check("rdwr_reg4_written", {32'd0, oregs[4*DW +: DW]}, 64'h0000_0000_1122_3344);

      // Write to reg 5 dropped while in WAIT: no change, no strobe.
      @(posedge clk); #1;
      wr = 1'b1; address = 11'h014; be = 4'hF; wdata = 32'h5555_AAAA;
      @(posedge clk); #1;
      wr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("drop_reg5_hold", {32'd0, oregs[5*DW +: DW]}, 64'd0);

      // Zero-wait-state instance: a single stall cycle.
      @(posedge clk); #1;
      rd0 = 1'b1;
      st0 = 0;
      @(negedge clk);
      while (waitreq0 && st0 < 40) begin
         st0++;
         @(negedge clk);
      end
      check("ws0_stalls", 64'(st0), 64'd1);
      check("ws0_rdata", {32'd0, rdata0}, 64'h0000_0000_DEAD_BEEF);
      @(posedge clk); #1;
      rd0 = 1'b0;

`ifdef AVS_REGFILE_IRQ_EN
      xfer(1'b0, 1'b1, 11'h024, 4'hF, 32'h0000_0001, st, ra);
      @(posedge clk); #1;
      irq_src[0] = 1'b1;
      @(posedge clk); #1;
      check("irq_assert", {63'd0, irq}, 64'd1);
      xfer(1'b0, 1'b1, 11'h020, 4'hF, 32'h0000_0001, st, ra);
      check("irq_clear", {63'd0, irq}, 64'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
         check($sformatf("strobe_count_%0d", i), 64'(strobe_cnt[i]), 64'(exp_strobe[i]));
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
